mlp_eval_sequencer: RTL and testbench

//  Parametrised successor to the MLP top-level control: runs a batch of test cases through an N-layer datapath.
//  Per case: clears the datapath, walks all layers with a start/done handshake, compares predicted class to label.
//  At batch end, computes accuracy with a sequential divider (no combinational divide).

---
 rtl/mlp_eval_pkg.sv | 31 +++
 rtl/mlp_seq_divider.sv | 80 ++++++++
 rtl/mlp_eval_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mlp_eval_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_eval_pkg.sv
// Shared types and defaults for the MLP evaluation sequencer and its layer datapath.
// Holds the FSM state encoding and width helpers.
package mlp_eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LSTART,
    LWAIT,
    SCORE,
    DIV,
    DONE
  } state_e;

  localparam int DEF_CASE_W    = 10;
  localparam int DEF_CLASS_W   = 4;
  localparam int DEF_N_CLASSES = 10;
  localparam int DEF_ACC_SCALE = 100;
  localparam int DEF_ACC_W     = 10;

  // Layer-select width: clog2 of the layer count, never narrower than one bit.
  function automatic int layer_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that must hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mlp_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle for NUM_W cycles.
// done and quotient are valid together in the final iteration cycle.
module mlp_seq_divider
  import mlp_eval_pkg::*;
#(
  parameter int NUM_W = 20,
  parameter int DEN_W = 10,
  parameter int QUO_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int CNT_W = cnt_w(NUM_W);

  logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d, rem_step;
  logic [NUM_W-1:0] quot_q, quot_d, quot_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DEN_W:0]   trial;

  // One restoring step: shift the next numerator bit into the partial remainder.
  always_comb begin
    trial = {rem_q, quot_q[NUM_W-1]};
    if (trial >= {1'b0, den_q}) begin
      rem_step  = DEN_W'(trial - {1'b0, den_q});
      quot_step = {quot_q[NUM_W-2:0], 1'b1};
    end else begin
      rem_step  = trial[DEN_W-1:0];
      quot_step = {quot_q[NUM_W-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      quot_d = numer;
      den_d  = denom;
      cnt_d  = CNT_W'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient = quot_step[QUO_W-1:0];

endmodule

// File: rtl/mlp_eval_sequencer.sv
// Batch controller for an N-layer MLP datapath: sequences layers per case, scores, divides out accuracy.
// Define MLP_EVAL_PERCLASS_EN to add per-class correct counters readable through class_sel.
module mlp_eval_sequencer
  import mlp_eval_pkg::*;
#(
  parameter int CASE_W     = DEF_CASE_W,
  parameter int NUM_LAYERS = 2,
  parameter int LAYER_W    = layer_w(NUM_LAYERS),
  parameter int CLASS_W    = DEF_CLASS_W,
  parameter int N_CLASSES  = DEF_N_CLASSES,
  parameter int ACC_SCALE  = DEF_ACC_SCALE,
  parameter int ACC_W      = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CASE_W-1:0]  num_cases,
  output logic [CASE_W-1:0]  case_addr,
  output logic               dp_init,
  output logic [LAYER_W-1:0] layer_sel,
  output logic               layer_start,
  input  logic               layer_done,
  input  logic [CLASS_W-1:0] pred_class,
  input  logic [CLASS_W-1:0] label,
  output logic               busy,
  output logic               done,
  output logic [CASE_W-1:0]  correct,
  output logic [ACC_W-1:0]   accuracy,
  input  logic [CLASS_W-1:0] class_sel,
  output logic [CASE_W-1:0]  class_correct
);

  localparam int NUM_W = CASE_W + ACC_W;

  state_e             state_q, state_d;
  logic [CASE_W-1:0]  num_cases_q, num_cases_d;
  logic [CASE_W-1:0]  case_addr_q, case_addr_d;
  logic [CASE_W-1:0]  correct_q, correct_d;
  logic [LAYER_W-1:0] layer_sel_q, layer_sel_d;
  logic [ACC_W-1:0]   accuracy_q, accuracy_d;
  logic               hit_q, hit_d;
  logic               last_done;
  logic               div_start, div_busy, div_done;
  logic [NUM_W-1:0]   div_numer;
  logic [ACC_W-1:0]   div_quot;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch; blocking '=' here, '<=' only in always_ff.
  always_comb begin
    state_d     = state_q;
    num_cases_d = num_cases_q;
    case_addr_d = case_addr_q;
    correct_d   = correct_q;
    layer_sel_d = layer_sel_q;
    accuracy_d  = accuracy_q;
    hit_d       = hit_q;
    last_done   = 1'b0;
    div_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_cases_d = num_cases;
          case_addr_d = '0;
          correct_d   = '0;
          layer_sel_d = '0;
          accuracy_d  = '0;
          hit_d       = 1'b0;
          state_d     = (num_cases == '0) ? DONE : INIT;
        end
      end
      INIT:   state_d = LSTART;
      LSTART: state_d = LWAIT;
      LWAIT: begin
        if (layer_done) begin
          if (layer_sel_q == LAYER_W'(NUM_LAYERS - 1)) begin
            last_done = 1'b1;
            hit_d     = (pred_class == label);
            state_d   = SCORE;
          end else begin
            layer_sel_d = layer_sel_q + LAYER_W'(1);
            state_d     = LSTART;
          end
        end
      end
      SCORE: begin
        correct_d   = correct_q + CASE_W'(hit_q);
        layer_sel_d = '0;
        if (case_addr_q != num_cases_q - CASE_W'(1)) begin
          case_addr_d = case_addr_q + CASE_W'(1);
          state_d     = INIT;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          accuracy_d = div_quot;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      num_cases_q <= '0;
      case_addr_q <= '0;
      correct_q   <= '0;
      layer_sel_q <= '0;
      accuracy_q  <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_cases_q <= num_cases_d;
      case_addr_q <= case_addr_d;
      correct_q   <= correct_d;
      layer_sel_q <= layer_sel_d;
      accuracy_q  <= accuracy_d;
      hit_q       <= hit_d;
    end
  end

  // Numerator uses the count including the final case scored this cycle.
  assign div_numer = NUM_W'(correct_d) * NUM_W'(ACC_SCALE);

  mlp_seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (CASE_W),
    .QUO_W (ACC_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst),
    .start    (div_start),
    .numer    (div_numer),
    .denom    (num_cases_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign case_addr   = case_addr_q;
  assign layer_sel   = layer_sel_q;
  assign dp_init     = (state_q == INIT);
  assign layer_start = (state_q == LSTART);
  assign done        = (state_q == DONE);
  assign busy        = (state_q inside {INIT, LSTART, LWAIT, SCORE}) || div_busy;
  assign correct     = correct_q;
  assign accuracy    = accuracy_q;

`ifdef MLP_EVAL_PERCLASS_EN
  logic [CASE_W-1:0]  cls_cnt_q [N_CLASSES];
  logic [CASE_W-1:0]  cls_cnt_d [N_CLASSES];
  logic [CLASS_W-1:0] cls_label_q, cls_label_d;

  // Out-of-range labels match no index, so they never touch a counter.
  always_comb begin
    cls_label_d = last_done ? label : cls_label_q;
    for (int i = 0; i < N_CLASSES; i++) begin
      cls_cnt_d[i] = cls_cnt_q[i];
      if (state_q == IDLE && start) begin
        cls_cnt_d[i] = '0;
      end else if (state_q == SCORE && hit_q && cls_label_q == CLASS_W'(i)) begin
        cls_cnt_d[i] = cls_cnt_q[i] + CASE_W'(1);
      end
    end
  end

  // NOTE: the counter array is reset explicitly because results must read 0
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_label_q <= '0;
      for (int i = 0; i < N_CLASSES; i++) cls_cnt_q[i] <= '0;
    end else begin
      cls_label_q <= cls_label_d;
      for (int i = 0; i < N_CLASSES; i++) cls_cnt_q[i] <= cls_cnt_d[i];
    end
  end

  always_comb begin
    class_correct = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (class_sel == CLASS_W'(i)) class_correct = cls_cnt_q[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg    = ^{class_sel, last_done, CLASS_W'(N_CLASSES)};
  assign class_correct = '0;
`endif

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// Scoreboard bench for mlp_eval_sequencer: percent and per-mille instances driven in lockstep.
// Honours MLP_EVAL_PERCLASS_EN for the per-class readout checks.
module tb_mlp_eval_sequencer;

  localparam int CASE_W  = 10;
  localparam int CLASS_W = 4;
  localparam int ACC_W   = 10;
  localparam int LAYER_W = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               layer_done = 1'b0;
  logic [CASE_W-1:0]  num_cases = '0;
  logic [CLASS_W-1:0] pred_class = '0;
  logic [CLASS_W-1:0] label = '0;
  logic [CLASS_W-1:0] class_sel = '0;

  logic [CASE_W-1:0]  case_addr, case_addr_pm;
  logic               dp_init, dp_init_pm;
  logic [LAYER_W-1:0] layer_sel, layer_sel_pm;
  logic               layer_start, layer_start_pm;
  logic               busy, busy_pm;
  logic               done, done_pm;
  logic [CASE_W-1:0]  correct, correct_pm;
  logic [ACC_W-1:0]   accuracy, accuracy_pm;
  logic [CASE_W-1:0]  class_correct, class_correct_pm;

  mlp_eval_sequencer #(.ACC_SCALE(100)) dut (
    .clk (clk), .rst (rst), .start (start), .num_cases (num_cases),
    .case_addr (case_addr), .dp_init (dp_init), .layer_sel (layer_sel),
    .layer_start (layer_start), .layer_done (layer_done),
    .pred_class (pred_class), .label (label), .busy (busy), .done (done),
    .correct (correct), .accuracy (accuracy), .class_sel (class_sel),
    .class_correct (class_correct)
  );

  mlp_eval_sequencer #(.ACC_SCALE(1000)) dut_pm (
    .clk (clk), .rst (rst), .start (start), .num_cases (num_cases),
    .case_addr (case_addr_pm), .dp_init (dp_init_pm), .layer_sel (layer_sel_pm),
    .layer_start (layer_start_pm), .layer_done (layer_done),
    .pred_class (pred_class), .label (label), .busy (busy_pm), .done (done_pm),
    .correct (correct_pm), .accuracy (accuracy_pm), .class_sel (class_sel),
    .class_correct (class_correct_pm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr;
    int acc;
    int acc_pm;
    int n_ls;
    int n_init;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [CLASS_W-1:0] pred_tbl [1024];
  logic [CLASS_W-1:0] lbl_tbl  [1024];
  int lat = 3;
  bit spurious = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Datapath model: answers each layer_start with a layer_done lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      layer_done = 1'b0;
      if (rst && layer_start) begin
        if (spurious) layer_done = 1'b1;
        repeat (lat) begin
          @(negedge clk);
          layer_done = 1'b0;
        end
        pred_class = pred_tbl[case_addr];
        label      = lbl_tbl[case_addr];
        layer_done = 1'b1;
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  int   ls_cnt = 0;
  int   init_cnt = 0;
  bit   prev_busy = 1'b0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        ls_cnt    = 0;
        init_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (layer_start) ls_cnt++;
        if (dp_init) init_cnt++;
        if (prev_busy && !busy) check("busy_drop_with_done", int'(done), 1);
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done (correct=%0d)", correct);
          end else begin
            e = exp_q.pop_front();
            check("correct", int'(correct), e.corr);
            check("accuracy_pct", int'(accuracy), e.acc);
            check("accuracy_pm", int'(accuracy_pm), e.acc_pm);
            check("done_pm_lockstep", int'(done_pm), 1);
            check("busy_at_done", int'(busy), 0);
            check("layer_start_count", ls_cnt, e.n_ls);
            check("dp_init_count", init_cnt, e.n_init);
          end
          ls_cnt   = 0;
          init_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    num_cases = CASE_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_batch(input int n, input int c, input int a, input int apm);
    exp_t x;
    x.corr = c; x.acc = a; x.acc_pm = apm; x.n_ls = 2 * n; x.n_init = n;
    exp_q.push_back(x);
    pulse_start(n);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, budget);
    end
  endtask

  task automatic set_case(input int i, input int lb, input int pr);
    lbl_tbl[i]  = CLASS_W'(lb);
    pred_tbl[i] = CLASS_W'(pr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) set_case(i, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_correct", int'(correct), 0);
    check("rst_accuracy", int'(accuracy), 0);
    check("rst_case_addr", int'(case_addr), 0);
    check("rst_layer_start", int'(layer_start), 0);
    check("rst_dp_init", int'(dp_init), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 4 cases, 3 cycle datapath, 3 matches.
    lat = 3;
    set_case(0, 1, 1); set_case(1, 2, 2); set_case(2, 3, 0); set_case(3, 4, 4);
    run_batch(4, 3, 75, 750);
    repeat (10) @(negedge clk);
    check("busy_mid_batch", int'(busy), 1);
    wait_done("batch4", 300);
    repeat (3) @(negedge clk);
    check("correct_held", int'(correct), 3);
    check("accuracy_held", int'(accuracy), 75);

    // Empty batch: straight to done, previous results cleared.
    run_batch(0, 0, 0, 0);
    wait_done("empty", 2);

    // Reset during case 2 of 5.
    for (int i = 0; i < 5; i++) set_case(i, i, i);
    pulse_start(5);
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        @(negedge clk);
        if (case_addr == CASE_W'(2)) break;
      end
      if (k == 300) begin
        checks++;
        errors++;
        $display("FAIL reach_case2_timeout: got case_addr=%0d expected 2", case_addr);
      end
    end
    check("pre_reset_correct", int'(correct), 2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_correct", int'(correct), 0);
    check("mid_rst_case_addr", int'(case_addr), 0);
    check("mid_rst_layer_sel", int'(layer_sel), 0);
    check("mid_rst_dp_init", int'(dp_init), 0);
    check("mid_rst_layer_start", int'(layer_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Clean 5 case batch, all correct.
    run_batch(5, 5, 100, 1000);
    wait_done("batch5", 400);
    class_sel = 4'd2;
    #1;
`ifndef MLP_EVAL_PERCLASS_EN
    check("class_correct_tied", int'(class_correct), 0);
`else
    check("class_correct_c2", int'(class_correct), 1);
`endif

    // Restart attempt and early layer_done during the batch are ignored.
    spurious = 1'b1;
    set_case(0, 0, 0); set_case(1, 5, 5); set_case(2, 9, 8);
    run_batch(3, 2, 66, 666);
    repeat (15) @(negedge clk);
    pulse_start(1);
    check("busy_after_restart", int'(busy), 1);
    wait_done("restart", 300);
    spurious = 1'b0;

    // 750 cases, 700 matches.
    lat = 1;
    for (int i = 0; i < 750; i++) set_case(i, i % 10, (i < 700) ? (i % 10) : ((i + 1) % 10));
    run_batch(750, 700, 93, 933);
    wait_done("batch750", 20000);

    // Labels 3,3,7 plus an out-of-range 12, all predicted correctly.
    lat = 2;
    set_case(0, 3, 3); set_case(1, 3, 3); set_case(2, 7, 7); set_case(3, 12, 12);
    run_batch(4, 4, 100, 1000);
    wait_done("perclass", 300);
    class_sel = 4'd3;
    #1;
`ifdef MLP_EVAL_PERCLASS_EN
    check("class_correct_c3", int'(class_correct), 2);
    class_sel = 4'd7;
    #1;
    check("class_correct_c7", int'(class_correct), 1);
    check("class_correct_c7_pm", int'(class_correct_pm), 1);
    class_sel = 4'd12;
    #1;
    check("class_correct_c12", int'(class_correct), 0);
`else
    check("class_correct_tied_c3", int'(class_correct), 0);
`endif

    repeat (5) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
